// File: rtl/demux_seq_pkg.sv
// Shared types and helpers for the demux channel sequencer.
// Channel-mask support is compiled in with DEMUX_SEQ_MASK_EN.
package demux_seq_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam int GAP_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Lowest enabled channel at/above `from`; all-ones when none is left.
  function automatic logic [SEL_W-1:0] next_ch(
    input logic [NUM_CH-1:0] mask,
    input logic [SEL_W-1:0]  from,
    input logic              incl
  );
    logic [SEL_W-1:0] r;
    r = '1;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (mask[k] && (k > int'(from) || (incl && k == int'(from))))
        r = SEL_W'(k);
    end
    return r;
  endfunction

  function automatic logic more_after(
    input logic [NUM_CH-1:0] mask,
    input logic [SEL_W-1:0]  from
  );
    logic r;
    r = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (mask[k] && k > int'(from))
        r = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/demux_seq_gap_timer.sv
// Loadable down-counter timing the inter-frame gap.
// done is high on the final counted cycle (or when empty).
module demux_seq_gap_timer
  import demux_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [GAP_W-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [GAP_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - GAP_W'(1);
    end
  end

  assign done = (cnt <= GAP_W'(1));

endmodule

// File: rtl/demux_channel_sequencer.sv
// Serialises 4-bit words onto a 1-to-4 demux, one channel per clock.
// Optional DEMUX_SEQ_MASK_EN adds a per-word channel mask.
module demux_channel_sequencer
  import demux_seq_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 0,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NUM_CH-1:0] in_data,
`ifdef DEMUX_SEQ_MASK_EN
  input  logic [NUM_CH-1:0] ch_mask,
`endif
  output logic              s1,
  output logic              s0,
  output logic              I,
  output logic              ch_valid,
  output logic              frame_done,
  output logic              busy
);

  localparam logic GAP_EN = (GAP_CYCLES != 0);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [NUM_CH-1:0] word_q, word_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [NUM_CH-1:0] mask_in;
  logic              last_q, last_d;
  logic              live_d, bit_d, done_d;
  logic              xfer, start, gap_load, gap_done;

`ifdef DEMUX_SEQ_MASK_EN
  assign mask_in = ch_mask;
`else
  assign mask_in = '1;
`endif

  assign in_ready = (state_q == IDLE) ||
                    (state_q == SHIFT && last_q && !GAP_EN);
  assign xfer = in_valid && in_ready;
  assign busy = (state_q != IDLE);
  assign s1   = sel_q[1];
  assign s0   = sel_q[0];

  demux_seq_gap_timer u_gap (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (gap_load),
    .load_val (GAP_W'(GAP_CYCLES)),
    .en       (state_q == GAP),
    .done     (gap_done)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    word_d   = word_q;
    mask_d   = mask_q;
    start    = 1'b0;
    gap_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer) start = 1'b1;
      end
      SHIFT: begin
        if (!last_q) begin
          sel_d = next_ch(mask_q, sel_q, 1'b0);
        end else if (GAP_EN) begin
          state_d  = GAP;
          sel_d    = '1;
          gap_load = 1'b1;
        end else if (xfer) begin
          start = 1'b1;
        end else begin
          state_d = IDLE;
          sel_d   = '0;
        end
      end
      GAP: begin
        if (gap_done) begin
          state_d = IDLE;
          sel_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase
    // An empty mask lands on sel=3 with no live channel: one frame_done cycle.
    if (start) begin
      state_d = SHIFT;
      word_d  = in_data;
      mask_d  = mask_in;
      sel_d   = next_ch(mask_in, '0, 1'b1);
    end
    last_d = !more_after(mask_d, sel_d);
    live_d = (state_d == SHIFT) && mask_d[sel_d];
    bit_d  = live_d ? word_d[sel_d] : IDLE_LEVEL;
    done_d = (state_d == SHIFT) && last_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      word_q     <= '0;
      mask_q     <= '0;
      last_q     <= 1'b0;
      I          <= IDLE_LEVEL;
      ch_valid   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      word_q     <= word_d;
      mask_q     <= mask_d;
      last_q     <= last_d;
      I          <= bit_d;
      ch_valid   <= live_d;
      frame_done <= done_d;
    end
  end

endmodule
